// File: rtl/cec_receiver_pkg.sv
// Shared HDMI-CEC timing windows (in 50 us ticks) and FSM encoding,
// used by both the CEC receiver and the CEC transmitter.
package cec_defs;

  localparam logic [6:0] START_LOW_MIN    = 7'd70;
  localparam logic [6:0] START_LOW_MAX    = 7'd78;
  localparam logic [6:0] START_PERIOD_MIN = 7'd86;
  localparam logic [6:0] START_PERIOD_MAX = 7'd94;
  localparam logic [6:0] BIT_SAMPLE       = 7'd21;
  localparam logic [6:0] BIT_PERIOD_MIN   = 7'd41;
  localparam logic [6:0] BIT_PERIOD_MAX   = 7'd55;
  localparam logic [6:0] ACK_LEN          = 7'd30;
  localparam logic [6:0] TICK_SAT         = 7'd127;

  localparam logic [3:0] BROADCAST_ADDR   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_START_HIGH,
    ST_BIT,
    ST_ACK_DRIVE
  } cec_state_t;

  function automatic logic in_window(input logic [6:0] t, input logic [6:0] lo,
                                     input logic [6:0] hi);
    return (t >= lo) && (t <= hi);
  endfunction

endpackage

// File: rtl/cec_receiver_if.sv
// Byte hand-off from the CEC receiver to the message layer.
// data_valid/data_error are one-cycle strobes with no backpressure: the sink
// must take data_* in the cycle data_valid is high; fields hold until the next byte.
interface cec_receiver_if;
  import cec_defs::*;

  logic [7:0] data_in;
  logic       data_eom;
  logic       data_header;
  logic       data_broadcast;
  logic       data_addressed;
  logic       data_valid;
  logic       data_error;
  cec_state_t rx_state;

  modport master (
    output data_in, data_eom, data_header, data_broadcast, data_addressed,
           data_valid, data_error, rx_state
  );

  modport slave (
    input data_in, data_eom, data_header, data_broadcast, data_addressed,
          data_valid, data_error, rx_state
  );

endinterface

// File: rtl/cec_receiver_line_filter.sv
// Synchronises the raw CEC line and accepts a level change only after
// FILTER_LEN consecutive equal samples; emits one-cycle fall/rise strobes.
module cec_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cec_in,
  output logic level,
  output logic fall,
  output logic rise
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // Idle CEC line is released (high), so the filter starts there.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      fall   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_1 <= cec_in;
      sync_2 <= sync_1;
      fall   <= 1'b0;
      rise   <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_2;
        cnt   <= '0;
        fall  <= ~sync_2;
        rise  <= sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cec_receiver.sv
// HDMI-CEC receiver: decodes start bit and 10-bit blocks from the filtered
// line, drives the ACK bit low for blocks addressed to us, and reports bytes.
module cec_receiver
  import cec_defs::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int TICK_HZ    = 20000,
  parameter int FILTER_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cec_in,
  input  logic [3:0]    my_addr,
  input  logic          tx_busy,
  output logic          cec_send,
  output logic          cec_out,
  cec_receiver_if.master rx
);

  localparam int CLKS_PER_TICK = CLK_FREQ / TICK_HZ;
  localparam int PW = $clog2(CLKS_PER_TICK);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);

  logic          level, fall, rise;
  logic [PW-1:0] presc;
  logic          tick;
  logic [6:0]    tcnt;

  cec_state_t    state;
  logic [3:0]    bit_idx;
  logic          sampled;
  logic          header;
  logic          eom;
  logic [7:0]    shreg;
  logic [3:0]    dest_q;
  logic [3:0]    dest_now;
  logic          ack_ok;

  logic [7:0]    d_in;
  logic          d_eom, d_header, d_broadcast, d_addressed, d_valid, d_error;

  cec_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk    (clk),
    .rst    (rst),
    .cec_in (cec_in),
    .level  (level),
    .fall   (fall),
    .rise   (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      tick  <= 1'b0;
      tcnt  <= '0;
    end else begin
      tick <= 1'b0;
      if (presc == PRESC_LAST) begin
        presc <= '0;
        tick  <= 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (fall)
        tcnt <= '0;
      else if (tick && tcnt != TICK_SAT)
        tcnt <= tcnt + 1'b1;
    end
  end

  // While the header is in flight the destination comes straight from the shifter.
  assign dest_now = header ? shreg[3:0] : dest_q;
  assign ack_ok   = (dest_now == my_addr) && (dest_now != BROADCAST_ADDR) && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_idx     <= '0;
      sampled     <= 1'b0;
      header      <= 1'b0;
      eom         <= 1'b0;
      shreg       <= '0;
      dest_q      <= '0;
      cec_send    <= 1'b0;
      d_in        <= '0;
      d_eom       <= 1'b0;
      d_header    <= 1'b0;
      d_broadcast <= 1'b0;
      d_addressed <= 1'b0;
      d_valid     <= 1'b0;
      d_error     <= 1'b0;
    end else begin
      d_valid <= 1'b0;
      d_error <= 1'b0;
      case (state)
        ST_IDLE: if (fall) state <= ST_START_LOW;
        ST_START_LOW: begin
          if (rise) begin
            if (in_window(tcnt, START_LOW_MIN, START_LOW_MAX)) begin
              state <= ST_START_HIGH;
            end else begin
              d_error <= 1'b1;
              state   <= ST_IDLE;
            end
          end else if (tcnt > START_LOW_MAX) begin
            d_error <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_START_HIGH: begin
          if (fall) begin
            if (in_window(tcnt, START_PERIOD_MIN, START_PERIOD_MAX)) begin
              state   <= ST_BIT;
              bit_idx <= '0;
              header  <= 1'b1;
              sampled <= 1'b0;
            end else begin
              d_error <= 1'b1;
              state   <= ST_IDLE;
            end
          end else if (tcnt > START_PERIOD_MAX) begin
            d_error <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_BIT, ST_ACK_DRIVE: begin
          if (!sampled && tcnt == BIT_SAMPLE) begin
            sampled <= 1'b1;
            if (bit_idx < 4'd8) begin
              shreg <= {shreg[6:0], level};
            end else if (bit_idx == 4'd8) begin
              eom <= level;
            end else begin
              d_valid     <= 1'b1;
              d_in        <= shreg;
              d_eom       <= eom;
              d_header    <= header;
              d_broadcast <= (dest_now == BROADCAST_ADDR);
              d_addressed <= (dest_now == my_addr);
              if (header) dest_q <= shreg[3:0];
              header <= 1'b0;
              if (eom && state == ST_BIT) state <= ST_IDLE;
            end
          end
          // Keep holding the line through the ACK sample; release at ACK_LEN.
          if (state == ST_ACK_DRIVE) begin
            if (tcnt == ACK_LEN) begin
              cec_send <= 1'b0;
              state    <= eom ? ST_IDLE : ST_BIT;
            end
          end else if (fall) begin
            if (tcnt < BIT_PERIOD_MIN) begin
              d_error <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              sampled <= 1'b0;
              bit_idx <= (bit_idx == 4'd9) ? 4'd0 : bit_idx + 4'd1;
              if (bit_idx == 4'd8 && ack_ok) begin
                cec_send <= 1'b1;
                state    <= ST_ACK_DRIVE;
              end
            end
          end else if (tcnt > BIT_PERIOD_MAX) begin
            d_error <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cec_out           = 1'b0;
  assign rx.data_in        = d_in;
  assign rx.data_eom       = d_eom;
  assign rx.data_header    = d_header;
  assign rx.data_broadcast = d_broadcast;
  assign rx.data_addressed = d_addressed;
  assign rx.data_valid     = d_valid;
  assign rx.data_error     = d_error;
  assign rx.rx_state       = state;

endmodule

// File: tb/tb_cec_receiver.sv
// Directed bench for cec_receiver: drives an initiator on a wired-AND CEC line
// with a shortened tick (8 clocks) and checks bytes, ACK drives and errors.
module tb_cec_receiver;
  import cec_defs::*;

  localparam int CPT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_line = 1'b1;
  logic       tx_busy = 1'b0;
  logic [3:0] my_addr = 4'h0;
  logic       cec_send;
  logic       cec_out;
  logic       cec_in;

  cec_receiver_if rx ();

  // Open-drain line: low if the initiator or the receiver pulls it down.
  assign cec_in = tx_line & ~(cec_send & ~cec_out);

  cec_receiver #(.CLK_FREQ(160000), .TICK_HZ(20000), .FILTER_LEN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cec_in   (cec_in),
    .my_addr  (my_addr),
    .tx_busy  (tx_busy),
    .cec_send (cec_send),
    .cec_out  (cec_out),
    .rx       (rx)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [11:0] exp_q[$];
  int          ack_cnt = 0;
  int          err_cnt = 0;
  int          ack_len = 0;
  logic        abort_ok = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rec(input logic hdr, input logic eom, input logic bc,
                                      input logic ad, input logic [7:0] b);
    return {hdr, eom, bc, ad, b};
  endfunction

  // Scoreboard and line monitor.
  always @(negedge clk) begin
    if (rx.data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_valid: got byte 0x%0h expected no strobe", rx.data_in);
      end else begin
        check("data_fields", {20'h0, rx.data_header, rx.data_eom, rx.data_broadcast,
                              rx.data_addressed, rx.data_in}, {20'h0, exp_q.pop_front()});
      end
    end
    if (rx.data_error) err_cnt++;
    if (cec_send) begin
      ack_len++;
    end else if (ack_len != 0) begin
      ack_cnt++;
      if (abort_ok) begin
        abort_ok = 1'b0;
      end else begin
        checks++;
        assert (ack_len >= 232 && ack_len <= 242) else begin
          errors++;
          $error("FAIL ack_len: got %0d cycles expected 232..242", ack_len);
        end
      end
      ack_len = 0;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * CPT) @(negedge clk);
  endtask

  task automatic send_start(input int low_t, input int period_t);
    tx_line = 1'b0;
    wait_ticks(low_t);
    tx_line = 1'b1;
    wait_ticks(period_t - low_t);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    int low_t;
    low_t = b ? 12 : 30;
    tx_line = 1'b0;
    wait_ticks(low_t);
    tx_line = 1'b1;
    if (glitch) begin
      wait_ticks(38 - low_t);
      tx_line = 1'b0;
      repeat (3) @(negedge clk);
      tx_line = 1'b1;
      repeat (10 * CPT - 3) @(negedge clk);
    end else begin
      wait_ticks(48 - low_t);
    end
  endtask

  task automatic send_block(input logic [7:0] d, input logic eom, input int glitch_bit);
    for (int i = 0; i < 8; i++) send_bit(d[7-i], i == glitch_bit);
    send_bit(eom, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_cec_send", 32'(cec_send), 0);
    check("rst_cec_out", 32'(cec_out), 0);
    check("rst_valid", 32'(rx.data_valid), 0);
    check("rst_error", 32'(rx.data_error), 0);
    check("rst_data_in", 32'(rx.data_in), 0);
    check("rst_state", 32'(rx.rx_state), 32'(ST_IDLE));
    rst = 1'b0;
    wait_ticks(10);

    // Header 0x40 EOM=1 to us at address 0.
    my_addr = 4'h0;
    exp_q.push_back(rec(1'b1, 1'b1, 1'b0, 1'b1, 8'h40));
    send_start(74, 90);
    send_block(8'h40, 1'b1, -1);
    wait_ticks(20);
    check("m1_ack_cnt", 32'(ack_cnt), 1);
    check("m1_pending", 32'(exp_q.size()), 0);
    check("m1_state", 32'(rx.rx_state), 32'(ST_IDLE));
    check("m1_err", 32'(err_cnt), 0);

    // Two-block message to address 4.
    my_addr = 4'h4;
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 1'b1, 8'h04));
    exp_q.push_back(rec(1'b0, 1'b1, 1'b0, 1'b1, 8'h36));
    send_start(74, 90);
    send_block(8'h04, 1'b0, -1);
    send_block(8'h36, 1'b1, -1);
    wait_ticks(20);
    check("m2_ack_cnt", 32'(ack_cnt), 3);
    check("m2_pending", 32'(exp_q.size()), 0);

    // Broadcast: decoded, never ACKed.
    exp_q.push_back(rec(1'b1, 1'b1, 1'b1, 1'b0, 8'h4F));
    send_start(74, 90);
    send_block(8'h4F, 1'b1, -1);
    wait_ticks(20);
    check("m3_ack_cnt", 32'(ack_cnt), 3);
    check("m3_pending", 32'(exp_q.size()), 0);

    // Short start bit (3.0 ms low) -> error, then a valid message to someone else.
    tx_line = 1'b0;
    wait_ticks(60);
    tx_line = 1'b1;
    wait_ticks(30);
    check("m4_err", 32'(err_cnt), 1);
    check("m4_state", 32'(rx.rx_state), 32'(ST_IDLE));
    exp_q.push_back(rec(1'b1, 1'b1, 1'b0, 1'b0, 8'h40));
    send_start(74, 90);
    send_block(8'h40, 1'b1, -1);
    wait_ticks(20);
    check("m4_ack_cnt", 32'(ack_cnt), 3);
    check("m4_pending", 32'(exp_q.size()), 0);

    // Own transmission: decoded but not ACKed.
    my_addr = 4'h0;
    tx_busy = 1'b1;
    exp_q.push_back(rec(1'b1, 1'b1, 1'b0, 1'b1, 8'h10));
    send_start(74, 90);
    send_block(8'h10, 1'b1, -1);
    wait_ticks(20);
    tx_busy = 1'b0;
    check("m5_ack_cnt", 32'(ack_cnt), 3);
    check("m5_pending", 32'(exp_q.size()), 0);

    // 3-cycle low glitch in bit 3 must be filtered out.
    my_addr = 4'h5;
    exp_q.push_back(rec(1'b1, 1'b1, 1'b0, 1'b1, 8'h25));
    send_start(74, 90);
    send_block(8'h25, 1'b1, 3);
    wait_ticks(20);
    check("m6_ack_cnt", 32'(ack_cnt), 4);
    check("m6_err", 32'(err_cnt), 1);
    check("m6_pending", 32'(exp_q.size()), 0);

    // Reset in the middle of an ACK drive.
    my_addr = 4'h0;
    send_start(74, 90);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h30 >> (7 - i)), 1'b0);
    send_bit(1'b1, 1'b0);
    tx_line = 1'b0;
    wait_ticks(12);
    tx_line = 1'b1;
    wait_ticks(2);
    check("m7_driving", 32'(cec_send), 1);
    check("m7_state_ack", 32'(rx.rx_state), 32'(ST_ACK_DRIVE));
    abort_ok = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("m7_rst_cec_send", 32'(cec_send), 0);
    check("m7_rst_data_in", 32'(rx.data_in), 0);
    check("m7_rst_header", 32'(rx.data_header), 0);
    check("m7_rst_valid", 32'(rx.data_valid), 0);
    check("m7_rst_state", 32'(rx.rx_state), 32'(ST_IDLE));
    wait_ticks(54);
    check("m7_ack_cnt", 32'(ack_cnt), 5);
    check("m7_err", 32'(err_cnt), 1);
    check("m7_pending", 32'(exp_q.size()), 0);

    // Following two-block message decodes normally.
    my_addr = 4'h3;
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 1'b1, 8'h03));
    exp_q.push_back(rec(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5));
    send_start(74, 90);
    send_block(8'h03, 1'b0, -1);
    send_block(8'hA5, 1'b1, -1);
    wait_ticks(20);
    check("m8_ack_cnt", 32'(ack_cnt), 7);
    check("m8_err", 32'(err_cnt), 1);
    check("m8_pending", 32'(exp_q.size()), 0);
    check("m8_state", 32'(rx.rx_state), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
